// File: rtl/lcd_char_ctrl.sv
// rtl/lcd_char_ctrl.sv - HD44780 character LCD driver with store-word command FIFO
module lcd_char_ctrl #(
    parameter int CMD_DEPTH   = 4,
    parameter int T_BOOT_CYC  = 750000,
    parameter int T_SETUP_CYC = 2,
    parameter int T_EN_CYC    = 12,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_CMD_CYC   = 2000,
    parameter int T_CLR_CYC   = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_valid,
    input  logic [31:0] i_wr_data,
    output logic        o_wr_ready,
    output logic [31:0] o_status,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int T_MAX = max2(max2(max2(T_BOOT_CYC, T_SETUP_CYC), max2(T_EN_CYC, T_HOLD_CYC)),
                                max2(max2(T_CMD_CYC, T_CLR_CYC), 2));
    localparam int TMR_W = $clog2(T_MAX);

    localparam logic [TMR_W-1:0] L_BOOT  = TMR_W'(T_BOOT_CYC - 1);
    localparam logic [TMR_W-1:0] L_SETUP = TMR_W'(T_SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] L_EN    = TMR_W'(T_EN_CYC - 1);
    localparam logic [TMR_W-1:0] L_HOLD  = TMR_W'(T_HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] L_CMD   = TMR_W'(T_CMD_CYC - 1);
    localparam logic [TMR_W-1:0] L_CLR   = TMR_W'(T_CLR_CYC - 1);
    localparam logic [PTR_W:0]   L_DEPTH = (PTR_W + 1)'(CMD_DEPTH);

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] w_tmr_nxt;

    logic [8:0]       r_mem [CMD_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic [7:0]       r_lcd_data;
    logic             r_lcd_rs;
    logic             r_lcd_en;
    logic             r_lcd_on;

    logic             w_full;
    logic             w_busy;
    logic             w_push;
    logic             w_pop;
    logic             w_is_clr;
    logic             w_unused;

    assign w_full   = (r_count == L_DEPTH);
    assign w_busy   = (r_state != S_IDLE) || (r_count != '0);
    assign w_push   = i_wr_valid && !i_wr_data[9] && !w_full;
    assign w_is_clr = !r_lcd_rs && ((r_lcd_data == 8'h01) || (r_lcd_data == 8'h02) ||
                                    (r_lcd_data == 8'h03));
    assign w_unused = ^i_wr_data[31:10];

    assign o_wr_ready = !w_full;
    assign o_status   = {24'b0, 6'(r_count), w_full, w_busy};
    assign o_lcd_data = r_lcd_data;
    assign o_lcd_rs   = r_lcd_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = r_lcd_en;
    assign o_lcd_on   = r_lcd_on;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_BOOT;
            r_tmr   <= L_BOOT;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    // One shared timer: each timed state loads its duration minus one on entry.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr - 1'b1;
        w_pop       = 1'b0;
        case (r_state)
            S_BOOT: begin
                if (r_tmr == '0) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                w_tmr_nxt = r_tmr;
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SETUP;
                    w_tmr_nxt   = L_SETUP;
                end
            end
            S_SETUP: begin
                if (r_tmr == '0) begin
                    w_state_nxt = S_PULSE;
                    w_tmr_nxt   = L_EN;
                end
            end
            S_PULSE: begin
                if (r_tmr == '0) begin
                    w_state_nxt = S_HOLD;
                    w_tmr_nxt   = L_HOLD;
                end
            end
            S_HOLD: begin
                if (r_tmr == '0) begin
                    w_state_nxt = S_WAIT;
                    w_tmr_nxt   = w_is_clr ? L_CLR : L_CMD;
                end
            end
            S_WAIT: begin
                if (r_tmr == '0) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_BOOT;
                w_tmr_nxt   = L_BOOT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data[8:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lcd_data <= 8'h00;
            r_lcd_rs   <= 1'b0;
            r_lcd_en   <= 1'b0;
            r_lcd_on   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (w_pop) {r_lcd_rs, r_lcd_data} <= r_mem[r_rd_ptr];
            // EN follows the next state so it is a clean flop aligned with PULSE.
            r_lcd_en <= (w_state_nxt == S_PULSE);
            if (i_wr_valid && i_wr_data[9]) r_lcd_on <= i_wr_data[0];
        end
    end

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// tb/tb_lcd_char_ctrl.sv - scoreboard bench for lcd_char_ctrl
module tb_lcd_char_ctrl;

    localparam int T_BOOT  = 10;
    localparam int T_SETUP = 2;
    localparam int T_EN    = 3;
    localparam int T_HOLD  = 2;
    localparam int T_CMD   = 20;
    localparam int T_CLR   = 50;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic [31:0] status;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        lcd_on;

    lcd_char_ctrl #(
        .CMD_DEPTH(DEPTH), .T_BOOT_CYC(T_BOOT), .T_SETUP_CYC(T_SETUP), .T_EN_CYC(T_EN),
        .T_HOLD_CYC(T_HOLD), .T_CMD_CYC(T_CMD), .T_CLR_CYC(T_CLR)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
        .o_wr_ready(wr_ready), .o_status(status), .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs),
        .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en), .o_lcd_on(lcd_on)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int r_ovf = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int         rise_q[$];
    int         fall_q[$];
    logic       prev_en = 1'b0;

    // Record every EN edge with the edge number and the bus value at the rise.
    always @(negedge clk) begin
        if (lcd_en === 1'b1 && prev_en === 1'b0) begin
            rise_q.push_back(cyc);
            obs_q.push_back({lcd_rs, lcd_data});
        end
        if (lcd_en === 1'b0 && prev_en === 1'b1) fall_q.push_back(cyc);
        prev_en = lcd_en;
    end

    task automatic clear_mon();
        rise_q.delete();
        fall_q.delete();
        obs_q.delete();
    endtask

    task automatic apply_reset(output int r);
        @(negedge clk);
        rst_n = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
    endtask

    task automatic push_one(input logic [31:0] w, output int n);
        wr_valid = 1'b1;
        wr_data = w;
        @(negedge clk);
        wr_valid = 1'b0;
        n = cyc;
    endtask

    task automatic test_reset();
        int r;
        bit en_seen;
        apply_reset(r);
        vectors++; if (status !== 32'h1) begin miscompares++; $display("FAIL rst_status: got %h expected 00000001", status); end
        vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b expected 1", wr_ready); end
        vectors++; if ({lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on} !== 12'h0) begin
            miscompares++; $display("FAIL rst_lcd: got data=%h rs=%b rw=%b en=%b on=%b expected all 0", lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on);
        end
        en_seen = 1'b0;
        for (int i = 1; i <= T_BOOT + 5; i++) begin
            @(negedge clk);
            if (lcd_en !== 1'b0) en_seen = 1'b1;
            if (i == T_BOOT - 1) begin
                vectors++; if (status !== 32'h1) begin miscompares++; $display("FAIL boot_busy: got %h expected 00000001", status); end
            end
            if (i == T_BOOT) begin
                vectors++; if (status !== 32'h0) begin miscompares++; $display("FAIL boot_done: got %h expected 00000000", status); end
            end
        end
        vectors++; if (en_seen !== 1'b0) begin miscompares++; $display("FAIL idle_no_en: got en pulse expected none"); end
    endtask

    task automatic test_single();
        int n;
        int busy_clr;
        logic [8:0] e;
        clear_mon();
        exp_q.push_back(9'h141);
        push_one(32'h0000_0141, n);
        busy_clr = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy_clr < 0 && status[0] === 1'b0) busy_clr = cyc;
        end
        vectors++; if (rise_q.size() != 1) begin miscompares++; $display("FAIL single_npulse: got %0d expected 1", rise_q.size()); end
        if (rise_q.size() >= 1 && fall_q.size() >= 1) begin
            vectors++; if (rise_q[0] != n + 1 + T_SETUP) begin miscompares++; $display("FAIL single_rise: got %0d expected %0d", rise_q[0] - n, 1 + T_SETUP); end
            vectors++; if (fall_q[0] - rise_q[0] != T_EN) begin miscompares++; $display("FAIL single_width: got %0d expected %0d", fall_q[0] - rise_q[0], T_EN); end
            vectors++; if (busy_clr != fall_q[0] + T_HOLD + T_CMD) begin miscompares++; $display("FAIL single_busy: got %0d expected %0d", busy_clr - fall_q[0], T_HOLD + T_CMD); end
        end
        if (obs_q.size() >= 1 && exp_q.size() >= 1) begin
            e = exp_q.pop_front();
            vectors++; if (obs_q[0] !== e) begin miscompares++; $display("FAIL single_data: got %h expected %h", obs_q[0], e); end
        end
        vectors++; if ({lcd_rs, lcd_data} !== 9'h141) begin miscompares++; $display("FAIL single_hold: got %h expected 141", {lcd_rs, lcd_data}); end
    endtask

    task automatic test_clear_gap();
        int n1;
        int n2;
        logic [8:0] e;
        clear_mon();
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h148);
        push_one(32'h0000_0001, n1);
        push_one(32'h0000_0148, n2);
        repeat (110) @(negedge clk);
        vectors++; if (rise_q.size() != 2) begin miscompares++; $display("FAIL clr_npulse: got %0d expected 2", rise_q.size()); end
        if (rise_q.size() == 2 && fall_q.size() >= 1) begin
            vectors++; if (rise_q[0] != n1 + 1 + T_SETUP) begin miscompares++; $display("FAIL clr_rise0: got %0d expected %0d", rise_q[0] - n1, 1 + T_SETUP); end
            vectors++; if (rise_q[1] - fall_q[0] != T_HOLD + T_CLR + 1 + T_SETUP) begin
                miscompares++; $display("FAIL clr_gap: got %0d expected %0d", rise_q[1] - fall_q[0], T_HOLD + T_CLR + 1 + T_SETUP);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (obs_q.size() > k && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++; if (obs_q[k] !== e) begin miscompares++; $display("FAIL clr_data%0d: got %h expected %h", k, obs_q[k], e); end
            end
        end
    endtask

    task automatic test_overflow();
        int r;
        clear_mon();
        exp_q.delete();
        apply_reset(r);
        r_ovf = r;
        for (int k = 0; k < 6; k++) begin
            wr_valid = 1'b1;
            wr_data = 32'h150 + k;
            if (k < DEPTH) exp_q.push_back(9'h150 + 9'(k));
            @(negedge clk);
        end
        wr_valid = 1'b0;
        vectors++; if (status !== 32'h13) begin miscompares++; $display("FAIL ovf_status: got %h expected 00000013", status); end
        vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_ready: got %b expected 0", wr_ready); end
    endtask

    task automatic test_power_write();
        int n;
        push_one(32'h0000_0201, n);
        vectors++; if (lcd_on !== 1'b1) begin miscompares++; $display("FAIL pwr_on: got %b expected 1", lcd_on); end
        vectors++; if (status !== 32'h13) begin miscompares++; $display("FAIL pwr_on_count: got %h expected 00000013", status); end
        push_one(32'h0000_0200, n);
        vectors++; if (lcd_on !== 1'b0) begin miscompares++; $display("FAIL pwr_off: got %b expected 0", lcd_on); end
        vectors++; if (status !== 32'h13) begin miscompares++; $display("FAIL pwr_off_count: got %h expected 00000013", status); end
    endtask

    task automatic test_drain();
        int period;
        logic [8:0] e;
        period = T_SETUP + T_EN + T_HOLD + T_CMD + 1;
        while (cyc < r_ovf + 160) @(negedge clk);
        vectors++; if (rise_q.size() != DEPTH) begin miscompares++; $display("FAIL drain_npulse: got %0d expected %0d", rise_q.size(), DEPTH); end
        for (int k = 0; k < DEPTH; k++) begin
            if (rise_q.size() > k) begin
                vectors++; if (rise_q[k] != r_ovf + T_BOOT + 1 + T_SETUP + k * period) begin
                    miscompares++; $display("FAIL drain_rise%0d: got %0d expected %0d", k, rise_q[k] - r_ovf, T_BOOT + 1 + T_SETUP + k * period);
                end
            end
            if (obs_q.size() > k && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++; if (obs_q[k] !== e) begin miscompares++; $display("FAIL drain_data%0d: got %h expected %h", k, obs_q[k], e); end
            end
        end
        vectors++; if (status !== 32'h0) begin miscompares++; $display("FAIL drain_idle: got %h expected 00000000", status); end
    endtask

    task automatic test_reset_mid_pulse();
        int n;
        int r;
        bit found;
        logic [8:0] e;
        clear_mon();
        exp_q.delete();
        push_one(32'h0000_0201, n);
        exp_q.push_back(9'h155);
        exp_q.push_back(9'h156);
        push_one(32'h0000_0155, n);
        push_one(32'h0000_0156, n);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (lcd_en === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL mid_wait_en: got no EN within 20 cycles expected pulse"); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        vectors++; if (lcd_en !== 1'b0) begin miscompares++; $display("FAIL mid_en: got %b expected 0", lcd_en); end
        vectors++; if (status !== 32'h1) begin miscompares++; $display("FAIL mid_status: got %h expected 00000001", status); end
        vectors++; if (lcd_on !== 1'b0) begin miscompares++; $display("FAIL mid_on: got %b expected 0", lcd_on); end
        if (obs_q.size() >= 1) begin
            e = exp_q.pop_front();
            vectors++; if (obs_q[0] !== e) begin miscompares++; $display("FAIL mid_data: got %h expected %h", obs_q[0], e); end
        end
        exp_q.delete();
        repeat (30) @(negedge clk);
        vectors++; if (rise_q.size() != 1) begin miscompares++; $display("FAIL mid_flush: got %0d pulses expected 1", rise_q.size()); end
        vectors++; if (status !== 32'h0) begin miscompares++; $display("FAIL mid_reboot: got %h expected 00000000", status); end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_valid = 1'b0;
        wr_data = 32'h0;
        test_reset();
        test_single();
        test_clear_gap();
        test_overflow();
        test_power_write();
        test_drain();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
